spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 193 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI-slave register bank (mode 0, MSB first) in the clk domain.
// sck, ncs and mosi are synchronised into clk, and edges are detected on the synchronised copies.
// Each frame is one command byte followed by zero or more DW-bit data words.
`timescale 1ns/1ps
module spi_reg_bank #(
    parameter int              NREG    = 4,
    parameter int              DW      = 32,
    parameter logic [NREG-1:0] WMASK   = {NREG{1'b1}},
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sck,
    input  logic                 ncs,
    input  logic                 mosi,
    output logic                 miso,
    output logic [NREG*DW-1:0]   q,
    input  logic [NREG*DW-1:0]   rd_d,
    output logic [NREG-1:0]      wr_stb,
    output logic                 busy
);

    localparam int              CW          = $clog2(DW);
    localparam logic [CW-1:0]   LAST_BIT    = CW'(DW - 1);
    localparam logic [CW-1:0]   CMD_LAST    = CW'(7);
    // The status byte sits in the top byte of tx, so it is shifted out first.
    localparam logic [DW-1:0]   STATUS_WORD = DW'({4'hA, 4'(NREG - 1)}) << (DW - 8);

    typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sck_sync_reg, ncs_sync_reg, mosi_sync_reg;
    logic              sck_prev_reg, ncs_prev_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [DW-1:0]     tx_reg;
    logic [DW-2:0]     rx_reg;
    logic [7:0]        cmd_reg;
    logic [3:0]        addr_reg;

    logic              sck_rise, sck_fall, ncs_rise, ncs_fall, mosi_bit;
    logic [7:0]        cmd_byte;
    logic [DW-1:0]     rx_word;
    logic              cmd_done, cmd_valid, word_done, do_write;
    logic [3:0]        addr_inc, addr_after;

    // Returns read-back word a; never indexes rd_d outside its NREG words.
    function automatic logic [DW-1:0] word_at(input logic [NREG*DW-1:0] bus, input logic [3:0] a);
        word_at = '0;
        for (int i = 0; i < NREG; i++)
            if (a == 4'(i)) word_at = bus[i*DW +: DW];
    endfunction

    function automatic logic writable(input logic [3:0] a);
        writable = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (a == 4'(i)) writable = WMASK[i];
    endfunction

    // Two-flop synchronisers plus a previous-value flop for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_sync_reg  <= 2'b00;
            ncs_sync_reg  <= 2'b11;
            mosi_sync_reg <= 2'b00;
            sck_prev_reg  <= 1'b0;
            ncs_prev_reg  <= 1'b1;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[0], sck};
            ncs_sync_reg  <= {ncs_sync_reg[0], ncs};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
            sck_prev_reg  <= sck_sync_reg[1];
            ncs_prev_reg  <= ncs_sync_reg[1];
        end
    end

    assign sck_rise = sck_sync_reg[1] & ~sck_prev_reg;
    assign sck_fall = ~sck_sync_reg[1] & sck_prev_reg;
    assign ncs_rise = ncs_sync_reg[1] & ~ncs_prev_reg;
    assign ncs_fall = ~ncs_sync_reg[1] & ncs_prev_reg;
    assign mosi_bit = mosi_sync_reg[1];

    assign cmd_byte   = {cmd_reg[6:0], mosi_bit};
    assign rx_word    = {rx_reg, mosi_bit};
    assign cmd_valid  = {1'b0, cmd_byte[3:0]} < 5'(NREG);
    // A rising ncs ends the frame, so the in-flight bit is never committed.
    assign cmd_done   = (state_reg == CMD) && !ncs_rise && sck_rise && (bit_cnt_reg == CMD_LAST);
    assign word_done  = (state_reg == DATA) && !ncs_rise && sck_rise && (bit_cnt_reg == LAST_BIT);
    assign do_write   = word_done && cmd_reg[7] && writable(addr_reg);
    assign addr_inc   = (addr_reg == 4'(NREG - 1)) ? 4'd0 : addr_reg + 4'd1;
    assign addr_after = cmd_reg[6] ? addr_inc : addr_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (ncs_fall) state_next = CMD;
            CMD: begin
                if (ncs_rise)      state_next = IDLE;
                else if (cmd_done) state_next = cmd_valid ? DATA : SKIP;
            end
            DATA:    if (ncs_rise) state_next = IDLE;
            SKIP:    if (ncs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift datapath: the bit counter, the rx/tx shifters, the command byte and the current address.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            cmd_reg     <= '0;
            addr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ncs_fall) begin
                        bit_cnt_reg <= '0;
                        tx_reg      <= STATUS_WORD;
                    end
                end
                CMD: begin
                    if (!ncs_rise) begin
                        if (sck_rise) begin
                            cmd_reg <= cmd_byte;
                            if (bit_cnt_reg == CMD_LAST) begin
                                bit_cnt_reg <= '0;
                                addr_reg    <= cmd_byte[3:0];
                                tx_reg      <= word_at(rd_d, cmd_byte[3:0]);
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CW'(1);
                            end
                        end else if (sck_fall && bit_cnt_reg != '0) begin
                            tx_reg <= tx_reg << 1;
                        end
                    end
                end
                DATA: begin
                    if (!ncs_rise) begin
                        if (sck_rise) begin
                            rx_reg <= rx_word[DW-2:0];
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                addr_reg    <= addr_after;
                                tx_reg      <= word_at(rd_d, addr_after);
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CW'(1);
                            end
                        end else if (sck_fall && bit_cnt_reg != '0) begin
                            tx_reg <= tx_reg << 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The data registers and their write strobes. Each register owns its
    // flops, and its slice of q and its bit of wr_stb come from continuous assigns.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [DW-1:0] word_reg;
        logic          stb_reg;
        logic          hit;

        assign hit = do_write && (addr_reg == 4'(gi));

        // Load the received word and raise the strobe for exactly one clk.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                word_reg <= RST_VAL;
                stb_reg  <= 1'b0;
            end else begin
                stb_reg <= hit;
                if (hit) word_reg <= rx_word;
            end
        end

        assign q[gi*DW +: DW] = word_reg;
        assign wr_stb[gi]     = stb_reg;
    end

    assign busy = (state_reg != IDLE);
    assign miso = ((state_reg == CMD) || (state_reg == DATA)) ? tx_reg[DW-1] : 1'b0;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank (NREG=4, DW=32), plus a second instance with WMASK=4'b1110.
// Expected miso words and write strobes are queued as the frames are driven.
// They are checked when the DUT shifts data out or raises a strobe.
`timescale 1ns/1ps
module tb_spi_reg_bank;

    logic         clk = 1'b0;
    logic         nrst, sck, ncs, mosi;
    logic         miso, busy, miso_m, busy_m;
    logic [127:0] q, q_m, rd_d;
    logic [3:0]   wr_stb, wr_stb_m;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } stb_t;

    logic [31:0] exp_miso[$];
    stb_t        exp_stb[$];
    logic [31:0] model [4];
    int          checks = 0;
    int          failures = 0;
    int          stb_m0_cnt = 0;

    spi_reg_bank #(.NREG(4), .DW(32)) dut (
        .clk(clk), .nrst(nrst), .sck(sck), .ncs(ncs), .mosi(mosi),
        .miso(miso), .q(q), .rd_d(rd_d), .wr_stb(wr_stb), .busy(busy)
    );

    spi_reg_bank #(.NREG(4), .DW(32), .WMASK(4'b1110)) dut_m (
        .clk(clk), .nrst(nrst), .sck(sck), .ncs(ncs), .mosi(mosi),
        .miso(miso_m), .q(q_m), .rd_d(rd_d), .wr_stb(wr_stb_m), .busy(busy_m)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [127:0] model_q();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic push_stb(input int idx, input logic [31:0] data);
        stb_t e;
        e.idx  = idx;
        e.data = data;
        exp_stb.push_back(e);
        model[idx] = data;
    endtask

    // Shift n bits of w out (MSB first) and sample miso just before each rising sck.
    task automatic spi_bits(input logic [31:0] w, input int n, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[31-i];
            #80;
            r = {r[30:0], miso};
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
    endtask

    // Pop the next expected miso word and compare it with what was shifted out.
    task automatic send(input string tag, input logic [31:0] w, input int n);
        logic [31:0] r;
        spi_bits(w, n, r);
        if (exp_miso.size() == 0) check_value({tag, "_sb_empty"}, 1, 0);
        else                      check_value(tag, r, exp_miso.pop_front());
    endtask

    task automatic start_frame();
        ncs = 1'b0;
        #200;
    endtask

    task automatic end_frame();
        #80;
        ncs = 1'b1;
        #300;
    endtask

    // Strobe monitor: every strobed cycle must match the next expected write.
    always @(negedge clk) begin
        if (nrst && wr_stb != 4'b0) begin
            if (exp_stb.size() == 0) begin
                check_value("unexpected_stb", wr_stb, 0);
            end else begin
                stb_t e;
                e = exp_stb.pop_front();
                check_value("stb_idx", wr_stb, 4'b0001 << e.idx);
                check_value("stb_data", q[e.idx*32 +: 32], e.data);
            end
        end
        if (nrst && wr_stb_m[0]) stb_m0_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] junk;
        for (int i = 0; i < 4; i++) model[i] = '0;
        rd_d = {32'h4444AAAA, 32'h33335555, 32'h12345678, 32'h0F0F0F0F};
        nrst = 1'b0; sck = 1'b0; ncs = 1'b1; mosi = 1'b0;
        #45;
        check_value("rst_q", q, 0);
        check_value("rst_stb", wr_stb, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_miso", miso, 0);
        nrst = 1'b1;
        #55;

        // Single write to register 0.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h0F0F0F0F);
        push_stb(0, 32'hDEADBEEF);
        start_frame();
        send("wr_cmd_status", 32'h80000000, 8);
        check_value("wr_busy", busy, 1);
        send("wr_data_miso", 32'hDEADBEEF, 32);
        end_frame();
        check_value("wr_q", q, model_q());
        check_value("wr_idle", busy, 0);

        // Read of register 1.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h12345678);
        start_frame();
        send("rd_cmd_status", 32'h01000000, 8);
        send("rd_data_miso", 32'h0, 32);
        end_frame();
        check_value("rd_q", q, model_q());

        // Burst write with auto-increment, wrapping from 3 to 0.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h33335555);
        exp_miso.push_back(32'h4444AAAA);
        exp_miso.push_back(32'h0F0F0F0F);
        push_stb(2, 32'h11111111);
        push_stb(3, 32'h22222222);
        push_stb(0, 32'h33333333);
        start_frame();
        send("burst_cmd", 32'hC2000000, 8);
        send("burst_w0", 32'h11111111, 32);
        send("burst_w1", 32'h22222222, 32);
        send("burst_w2", 32'h33333333, 32);
        end_frame();
        check_value("burst_q", q, model_q());

        // Aborted write: ncs rises after 16 data bits.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h1234);
        start_frame();
        send("abort_cmd", 32'h81000000, 8);
        send("abort_part", 32'hBEEF0000, 16);
        end_frame();
        check_value("abort_q", q, model_q());

        // Out-of-range address: the frame is skipped and miso stays low.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h0);
        start_frame();
        send("oor_cmd", 32'h89000000, 8);
        send("oor_miso", 32'hFFFFFFFF, 32);
        end_frame();
        check_value("oor_q", q, model_q());
        check_value("oor_idle", busy, 0);

        // Write to register 0: the masked instance must ignore it.
        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h0F0F0F0F);
        push_stb(0, 32'h5A5A5A5A);
        start_frame();
        send("wm_cmd", 32'h80000000, 8);
        send("wm_data", 32'h5A5A5A5A, 32);
        end_frame();
        check_value("wm_q", q, model_q());
        check_value("wm_masked_reg0", q_m[31:0], 0);
        check_value("wm_masked_reg32", q_m[127:64], {32'h22222222, 32'h11111111});

        // Reset in the middle of a DATA word.
        exp_miso.push_back(32'hA3);
        start_frame();
        send("mid_cmd", 32'h80000000, 8);
        spi_bits(32'hFFFF0000, 16, junk);
        nrst = 1'b0;
        #1;
        check_value("mid_busy", busy, 0);
        check_value("mid_miso", miso, 0);
        check_value("mid_q", q, 0);
        check_value("mid_stb", wr_stb, 0);
        for (int i = 0; i < 4; i++) model[i] = '0;
        ncs = 1'b1;
        #49;
        nrst = 1'b1;
        #200;
        check_value("mid_no_restart", busy, 0);

        exp_miso.push_back(32'hA3);
        exp_miso.push_back(32'h0F0F0F0F);
        push_stb(0, 32'h0000FFFF);
        start_frame();
        send("post_cmd", 32'h80000000, 8);
        send("post_data", 32'h0000FFFF, 32);
        end_frame();
        check_value("post_q", q, model_q());

        #200;
        check_value("stb_pending", exp_stb.size(), 0);
        check_value("miso_pending", exp_miso.size(), 0);
        check_value("masked_stb0_count", stb_m0_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
